// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the memory arbiter and the unified RAM.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_valid;

  logic              err;

  modport slave (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ram_rdata, ram_valid,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, err
  );

  modport master (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ram_rdata, ram_valid,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and the MEM stage,
// with a data-streak starvation guard and a completion timeout.
//
// state | meaning
// IDLE  | sample requests, pick and latch a winner
// ISSUE | ram_en strobe for one cycle
// WAIT  | wait for ram_valid or timeout
// RESP  | owner's ready pulse (err on timeout)
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner_data;
  logic [SW-1:0] streak;
  logic [WW-1:0] wait_left;
  logic          data_req;
  logic          if_win;

  assign data_req = bus.mem_rd_en | bus.mem_wr_en;
  assign if_win   = bus.if_req & (~data_req | (streak == SW'(MAX_DATA_STREAK)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner_data    <= 1'b0;
      streak        <= '0;
      wait_left     <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= {ADDR_W{1'b0}};
      bus.ram_wdata <= {DATA_W{1'b0}};
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.mem_rdata <= {DATA_W{1'b0}};
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.ram_en    <= 1'b0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            owner_data    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= bus.if_addr;
            bus.ram_wdata <= '0;
            bus.ram_en    <= 1'b1;
            streak        <= '0;
            state         <= ISSUE;
          end else if (data_req) begin
            owner_data    <= 1'b1;
            bus.ram_we    <= bus.mem_wr_en;
            bus.ram_addr  <= bus.mem_addr;
            bus.ram_wdata <= bus.mem_wdata;
            bus.ram_en    <= 1'b1;
            // streak only grows while a fetch is actually being held off
            if (!bus.if_req)
              streak <= '0;
            else if (streak != SW'(MAX_DATA_STREAK))
              streak <= streak + 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wait_left <= WW'(TIMEOUT);
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.ram_valid || (wait_left == '0)) begin
            if (owner_data) begin
              if (!bus.ram_we)
                bus.mem_rdata <= bus.ram_valid ? bus.ram_rdata : '0;
              bus.mem_ready <= 1'b1;
            end else begin
              bus.if_rdata <= bus.ram_valid ? bus.ram_rdata : '0;
              bus.if_ready <= 1'b1;
            end
            bus.err <= ~bus.ram_valid;
            state   <= RESP;
          end else begin
            wait_left <= wait_left - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, arbitration, streak guard, store,
// timeout and mid-access reset, against a latency-programmable memory responder.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(4), .TIMEOUT(255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hE3A01005 : (a ^ 32'h5A5A_0000);
  endfunction

  // memory responder and activity monitor
  int          lat = 1;
  bit          resp_on = 1'b1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic        resp_valid = 1'b0;
  logic        inject_valid = 1'b0;
  logic [31:0] resp_addr = '0;
  logic [31:0] valid_wdata = '0;
  int          en_cnt = 0;
  int          last_en_cyc = 0;
  int          memr_cnt = 0;
  logic [31:0] addr_log[$];
  logic        we_log[$];

  assign bus.ram_valid = resp_valid | inject_valid;
  assign bus.ram_rdata = resp_valid ? mem_word(resp_addr) : 32'hBAD0BAD0;

  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pend        = 1'b0;
        resp_valid  = resp_on;
        valid_wdata = bus.ram_wdata;
      end
    end
    if (bus.ram_en) begin
      pend        = 1'b1;
      cnt         = lat;
      resp_addr   = bus.ram_addr;
      en_cnt      = en_cnt + 1;
      last_en_cyc = cyc;
      addr_log.push_back(bus.ram_addr);
      we_log.push_back(bus.ram_we);
    end
    if (bus.mem_ready) memr_cnt = memr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // sel: 0 = if_ready, 1 = mem_ready, 2 = either
  task automatic wait_rdy(input string tag, input int sel, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if ((sel == 0 && bus.if_ready) || (sel == 1 && bus.mem_ready) ||
          (sel == 2 && (bus.if_ready || bus.mem_ready))) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check_val({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          c;
    int          t;
    int          m0;
    int          e0;
    logic [31:0] exp_a[6];
    exp_a = '{32'h300, 32'h300, 32'h300, 32'h300, 32'hC0, 32'h300};

    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_if_ready",  64'(bus.if_ready),  64'd0);
    check_val("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check_val("rst_ram_en",    64'(bus.ram_en),    64'd0);
    check_val("rst_ram_we",    64'(bus.ram_we),    64'd0);
    check_val("rst_err",       64'(bus.err),       64'd0);
    check_val("rst_ram_addr",  64'(bus.ram_addr),  64'd0);
    check_val("rst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
    check_val("rst_if_rdata",  64'(bus.if_rdata),  64'd0);
    check_val("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single fetch, 1-cycle memory
    @(negedge clk); #1;
    c = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    lat = 1;
    wait_rdy("fetch", 0, 10, t);
    bus.if_req = 1'b0;
    check_val("fetch_en_cyc",    64'(last_en_cyc),  64'(c + 1));
    check_val("fetch_rdy_cyc",   64'(t),            64'(c + 3));
    check_val("fetch_rdata",     64'(bus.if_rdata), 64'hE3A01005);
    check_val("fetch_we",        64'(we_log[$]),    64'd0);
    check_val("fetch_mem_ready", 64'(bus.mem_ready), 64'd0);

    // simultaneous fetch and load: data first, then fetch
    @(negedge clk); #1;
    addr_log.delete();
    we_log.delete();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h80;
    bus.mem_rd_en = 1'b1;
    bus.mem_addr  = 32'h100;
    lat = 2;
    wait_rdy("sim_data", 1, 12, t);
    bus.mem_rd_en = 1'b0;
    check_val("sim_data_rdata", 64'(bus.mem_rdata), 64'h5A5A0100);
    check_val("sim_if_idle",    64'(bus.if_ready),  64'd0);
    wait_rdy("sim_if", 0, 12, t);
    bus.if_req = 1'b0;
    check_val("sim_if_rdata", 64'(bus.if_rdata),  64'h5A5A0080);
    check_val("sim_mem_hold", 64'(bus.mem_rdata), 64'h5A5A0100);
    check_val("sim_order0",   64'(addr_log[0]),   64'h100);
    check_val("sim_order1",   64'(addr_log[1]),   64'h80);

    // streak guard: writes held with fetch pending
    @(negedge clk); #1;
    addr_log.delete();
    we_log.delete();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'hC0;
    bus.mem_wr_en = 1'b1;
    bus.mem_addr  = 32'h300;
    bus.mem_wdata = 32'h11110000;
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      wait_rdy("streak_rdy", 2, 12, t);
      if (bus.if_ready) bus.if_req = 1'b0;
      if (i == 5) bus.mem_wr_en = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("streak_addr%0d", i), 64'(addr_log[i]), 64'(exp_a[i]));
      check_val($sformatf("streak_we%0d", i),   64'(we_log[i]),   64'((i == 4) ? 0 : 1));
    end
    check_val("streak_mem_rdata", 64'(bus.mem_rdata), 64'h5A5A0100);

    // store with rd and wr both high, 3-cycle memory
    @(negedge clk); #1;
    c = cyc;
    bus.mem_rd_en = 1'b1;
    bus.mem_wr_en = 1'b1;
    bus.mem_addr  = 32'h200;
    bus.mem_wdata = 32'hDEADBEEF;
    lat = 3;
    wait_rdy("store", 1, 12, t);
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    check_val("store_rdy_cyc",   64'(t),              64'(c + 5));
    check_val("store_we",        64'(we_log[$]),      64'd1);
    check_val("store_wdata_vld", 64'(valid_wdata),    64'hDEADBEEF);
    check_val("store_addr_held", 64'(bus.ram_addr),   64'h200);
    check_val("store_mem_rdata", 64'(bus.mem_rdata),  64'h5A5A0100);
    check_val("store_err",       64'(bus.err),        64'd0);

    // timeout: memory never answers
    @(negedge clk); #1;
    c = cyc;
    resp_on = 1'b0;
    bus.mem_rd_en = 1'b1;
    bus.mem_addr  = 32'h104;
    lat = 1;
    wait_rdy("tmo", 1, 300, t);
    bus.mem_rd_en = 1'b0;
    check_val("tmo_rdy_cyc", 64'(t),             64'(c + 258));
    check_val("tmo_err",     64'(bus.err),       64'd1);
    check_val("tmo_rdata",   64'(bus.mem_rdata), 64'd0);
    m0 = memr_cnt;
    e0 = en_cnt;
    resp_on = 1'b1;
    @(negedge clk); #1;
    check_val("tmo_err_pulse", 64'(bus.err), 64'd0);
    inject_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    inject_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("late_valid_ready", 64'(memr_cnt), 64'(m0));
    check_val("late_valid_en",    64'(en_cnt),   64'(e0));
    check_val("late_valid_err",   64'(bus.err),  64'd0);

    // asynchronous reset during WAIT
    @(negedge clk); #1;
    e0 = en_cnt;
    m0 = memr_cnt;
    bus.mem_rd_en = 1'b1;
    bus.mem_addr  = 32'h108;
    lat = 5;
    for (int i = 0; i < 10 && en_cnt == e0; i++) begin
      @(negedge clk); #1;
    end
    check_val("arst_en_seen", 64'(en_cnt - e0), 64'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("arst_ram_addr",  64'(bus.ram_addr),  64'd0);
    check_val("arst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
    check_val("arst_if_rdata",  64'(bus.if_rdata),  64'd0);
    check_val("arst_ram_en",    64'(bus.ram_en),    64'd0);
    check_val("arst_mem_ready", 64'(bus.mem_ready), 64'd0);
    bus.mem_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check_val("arst_no_ready", 64'(memr_cnt), 64'(m0));
    c = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    lat = 1;
    wait_rdy("arst_fetch", 0, 10, t);
    bus.if_req = 1'b0;
    check_val("arst_fetch_cyc",   64'(t),            64'(c + 3));
    check_val("arst_fetch_rdata", 64'(bus.if_rdata), 64'hE3A01005);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
